// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe
// Registered, handshaked decode/control stage that sits between the IFU and
// the EXU. It decodes RV32I (plus RV32M when ENABLE_M=1) and flags illegal
// encodings. The result goes into a one-entry output register under
// valid/ready flow control. An accepted M instruction stalls the stage for the
// multiplier/divider latency before its bundle may be consumed.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    IFU handshake; in_inst/in_pc are the fetched word/PC
//   out_valid/out_ready  EXU handshake; out_pc/out_inst are the registered copies
//   ext_op..mem_ren      registered control bundle
//   mdu_op, mdu_start    M-extension op (func3) and one-cycle issue pulse
//   illegal              bundle holds an illegal instruction
//   busy                 MDU wait/hold sequence in progress
module decode_ctrl_pipe #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1,
    parameter int MUL_LAT  = 3,
    parameter int DIV_LAT  = 33
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_inst,
    output logic [2:0]      ext_op,
    output logic            reg_wen,
    output logic [1:0]      reg_wb_sel,
    output logic            alu_asrc,
    output logic            alu_bsrc,
    output logic [3:0]      alu_op,
    output logic            do_branch,
    output logic            do_jump,
    output logic [2:0]      branch_cond,
    output logic [2:0]      mem_op,
    output logic            mem_wen,
    output logic            mem_ren,
    output logic [2:0]      mdu_op,
    output logic            mdu_start,
    output logic            illegal,
    output logic            busy
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT) + 1;
    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT - 1);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] EXT_I = 3'd0;
    localparam logic [2:0] EXT_U = 3'd1;
    localparam logic [2:0] EXT_S = 3'd2;
    localparam logic [2:0] EXT_B = 3'd3;
    localparam logic [2:0] EXT_J = 3'd4;
    localparam logic [2:0] EXT_R = 3'd5;
    localparam logic [2:0] EXT_X = 3'd7;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SLTU   = 4'b1010;
    localparam logic [3:0] ALU_COPY_B = 4'b1111;

    typedef struct packed {
        logic [2:0] ext_op;
        logic       reg_wen;
        logic [1:0] reg_wb_sel;
        logic       alu_asrc;
        logic       alu_bsrc;
        logic [3:0] alu_op;
        logic       do_branch;
        logic       do_jump;
        logic [2:0] branch_cond;
        logic [2:0] mem_op;
        logic       mem_wen;
        logic       mem_ren;
        logic [2:0] mdu_op;
        logic       illegal;
    } ctrl_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MWAIT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    ctrl_t      dec;
    logic       dec_legal;
    logic       dec_is_m;

    assign opcode = in_inst[6:0];
    assign func3  = in_inst[14:12];
    assign func7  = in_inst[31:25];

    always_comb begin
        dec       = '0;
        dec_legal = 1'b0;
        dec_is_m  = 1'b0;
        case (opcode)
            OP_LUI: begin
                dec_legal      = 1'b1;
                dec.ext_op     = EXT_U;
                dec.reg_wen    = 1'b1;
                dec.alu_op     = ALU_COPY_B;
            end
            OP_AUIPC: begin
                dec_legal      = 1'b1;
                dec.ext_op     = EXT_U;
                dec.reg_wen    = 1'b1;
                dec.alu_asrc   = 1'b1;
                dec.alu_op     = ALU_ADD;
            end
            OP_JAL: begin
                dec_legal      = 1'b1;
                dec.ext_op     = EXT_J;
                dec.reg_wen    = 1'b1;
                dec.reg_wb_sel = 2'd2;
                dec.alu_asrc   = 1'b1;
                dec.alu_op     = ALU_ADD;
                dec.do_jump    = 1'b1;
            end
            OP_JALR: begin
                dec_legal      = (func3 == 3'b000);
                dec.ext_op     = EXT_I;
                dec.reg_wen    = 1'b1;
                dec.reg_wb_sel = 2'd2;
                dec.alu_op     = ALU_ADD;
                dec.do_jump    = 1'b1;
            end
            OP_BRANCH: begin
                dec_legal       = (func3 != 3'b010) && (func3 != 3'b011);
                dec.ext_op      = EXT_B;
                dec.alu_asrc    = 1'b1;
                dec.alu_op      = ALU_ADD;
                dec.do_branch   = 1'b1;
                dec.branch_cond = func3;
            end
            OP_LOAD: begin
                dec_legal      = (func3 != 3'b011) && (func3 != 3'b110) && (func3 != 3'b111);
                dec.ext_op     = EXT_I;
                dec.reg_wen    = 1'b1;
                dec.reg_wb_sel = 2'd1;
                dec.alu_op     = ALU_ADD;
                dec.mem_op     = func3;
                dec.mem_ren    = 1'b1;
            end
            OP_STORE: begin
                dec_legal      = (func3 <= 3'b010);
                dec.ext_op     = EXT_S;
                dec.alu_op     = ALU_ADD;
                dec.mem_op     = func3;
                dec.mem_wen    = 1'b1;
            end
            OP_IMM: begin
                // Shift-immediates carry func7 in imm[11:5]; only srai may set bit 5.
                if (func3 == 3'b001) begin
                    dec_legal = (func7 == 7'b0000000);
                end else if (func3 == 3'b101) begin
                    dec_legal = (func7 == 7'b0000000) || (func7 == 7'b0100000);
                end else begin
                    dec_legal = 1'b1;
                end
                dec.ext_op  = EXT_I;
                dec.reg_wen = 1'b1;
                if (func3 == 3'b101) begin
                    dec.alu_op = {func7[5], func3};
                end else if (func3 == 3'b011) begin
                    dec.alu_op = ALU_SLTU;
                end else begin
                    dec.alu_op = {1'b0, func3};
                end
            end
            OP_REG: begin
                dec.ext_op   = EXT_R;
                dec.reg_wen  = 1'b1;
                dec.alu_bsrc = 1'b1;
                if (ENABLE_M && (func7 == 7'b0000001)) begin
                    dec_legal      = 1'b1;
                    dec_is_m       = 1'b1;
                    dec.reg_wb_sel = 2'd3;
                    dec.alu_op     = ALU_ADD;
                    dec.mdu_op     = func3;
                end else begin
                    dec_legal = (func7 == 7'b0000000) ||
                                ((func7 == 7'b0100000) && ((func3 == 3'b000) || (func3 == 3'b101)));
                    // The SLTU encoding does not follow the {func7[5], func3} pattern.
                    if (func3 == 3'b011) begin
                        dec.alu_op = ALU_SLTU;
                    end else begin
                        dec.alu_op = {func7[5], func3};
                    end
                end
            end
            OP_FENCE, OP_SYSTEM: begin
                // Recognised but needs no datapath action in this stage.
                dec_legal = 1'b1;
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase

        if (!dec_legal) begin
            dec          = '0;
            dec.ext_op   = EXT_X;
            dec.illegal  = 1'b1;
            dec_is_m     = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Handshake and output register
    // ------------------------------------------------------------------
    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [CW-1:0]   issue_cnt;
    logic            out_valid_reg;
    ctrl_t           ctrl_reg;
    logic [XLEN-1:0] pc_reg;
    logic [31:0]     inst_reg;
    logic            mdu_start_reg;
    logic            in_fire;
    logic            out_fire;

    assign in_ready  = (state_reg == IDLE) && (!out_valid_reg || out_ready);
    assign in_fire   = in_valid && in_ready;
    // While the MDU is still computing the bundle is visible but not consumable.
    assign out_fire  = out_valid_reg && out_ready && (state_reg != MWAIT);
    assign issue_cnt = dec.mdu_op[2] ? DIV_CNT : MUL_CNT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            ctrl_reg      <= '0;
            pc_reg        <= '0;
            inst_reg      <= '0;
            mdu_start_reg <= 1'b0;
            state_reg     <= IDLE;
            cnt_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            mdu_start_reg <= in_fire && dec_is_m;
            if (in_fire) begin
                out_valid_reg <= 1'b1;
                ctrl_reg      <= dec;
                pc_reg        <= in_pc;
                inst_reg      <= in_inst;
            end else if (out_fire) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // MDU issue FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (in_fire && dec_is_m) begin
                    cnt_next = issue_cnt;
                    // A single-cycle unit needs no wait phase at all.
                    state_next = (issue_cnt == '0) ? HOLD : MWAIT;
                end
            end
            MWAIT: begin
                if (cnt_reg == '0) begin
                    state_next = HOLD;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            HOLD: begin
                if (out_fire) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign out_valid   = out_valid_reg;
    assign out_pc      = pc_reg;
    assign out_inst    = inst_reg;
    assign ext_op      = ctrl_reg.ext_op;
    assign reg_wen     = ctrl_reg.reg_wen;
    assign reg_wb_sel  = ctrl_reg.reg_wb_sel;
    assign alu_asrc    = ctrl_reg.alu_asrc;
    assign alu_bsrc    = ctrl_reg.alu_bsrc;
    assign alu_op      = ctrl_reg.alu_op;
    assign do_branch   = ctrl_reg.do_branch;
    assign do_jump     = ctrl_reg.do_jump;
    assign branch_cond = ctrl_reg.branch_cond;
    assign mem_op      = ctrl_reg.mem_op;
    assign mem_wen     = ctrl_reg.mem_wen;
    assign mem_ren     = ctrl_reg.mem_ren;
    assign mdu_op      = ctrl_reg.mdu_op;
    assign illegal     = ctrl_reg.illegal;
    assign mdu_start   = mdu_start_reg;
    assign busy        = (state_reg != IDLE);

endmodule

// File: doc/decode_ctrl_pipe.md
Name: decode_ctrl_pipe

Overview:
- Registered, handshaked decode/control stage: takes fetched instruction + PC from IFU, emits a registered control bundle to EXU.
- Generalises the combinational control generator:
  - valid/ready flow control with a one-entry output register;
  - optional RV32M decode;
  - illegal-instruction detection;
  - a multi-cycle MDU issue FSM that stalls the pipe for a parametrised latency.
- Sits between IFU and EXU in npc.

Parameters:
- XLEN, 32, datapath/PC width.
- ENABLE_M, 1, 1 = decode RV32M (opcode 0110011, func7 0000001); 0 = those encodings are illegal.
- MUL_LAT, 3, cycles EXU multiplier needs after issue (≥1).
- DIV_LAT, 33, cycles EXU divider needs after issue (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  IFU has instruction
- in_ready  out  1  stage can accept this cycle
- in_inst  in  32  instruction
- in_pc  in  XLEN  instruction PC
- out_valid  out  1  control bundle valid
- out_ready  in  1  EXU consumes bundle
- out_pc  out  XLEN  registered PC
- out_inst  out  32  registered instruction
- ext_op  out  3  I=0,U=1,S=2,B=3,J=4,R=5,default=7
- reg_wen  out  1  register write
- reg_wb_sel  out  2  ALU=0,MEM=1,PC+4=2,MDU=3
- alu_asrc  out  1  0=rs1, 1=PC (auipc, jal, branch)
- alu_bsrc  out  1  0=imm, 1=rs2 (R-type)
- alu_op  out  4  ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 1010, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111, COPY_B 1111
- do_branch, do_jump  out  1 each
- branch_cond  out  3  func3 for B-type, else 000
- mem_op  out  3  func3 for load/store, else 000
- mem_wen, mem_ren  out  1 each
- mdu_op  out  3  func3 of M instruction, else 000
- mdu_start  out  1  one-cycle pulse, first cycle an M bundle is valid
- illegal  out  1  bundle is an illegal instruction
- busy  out  1  FSM not IDLE

Behaviour:
- Reset (async, immediate):
  - out_valid=0, all control outputs 0, out_pc=0, out_inst=0, illegal=0, mdu_start=0, busy=0, FSM=IDLE.
- Decode is combinational on in_inst.
- Non-M decode is the established RV32I mapping:
  - I-int sltiu → SLTU; srli/srai select via func7[5].
  - R-type add/sub and srl/sra select via func7[5].
  - load/store/jal/jalr/auipc → ADD; lui → COPY_B.
- M-type decode: alu_op=ADD, reg_wen=1, reg_wb_sel=3, mdu_op=func3.
- Legality: illegal=1 when any of:
  - opcode is not in the RV32I set (+M when enabled);
  - R-type func7 is not 0000000/0100000 (0100000 only with func3 000/101), or 0000001 when ENABLE_M=1;
  - shift-immediate func7 is invalid;
  - load func3 ∈ {011,110,111};
  - store func3 > 010;
  - branch func3 ∈ {010,011};
  - jalr func3 ≠ 000.
- Illegal bundle: all write/mem/branch/jump enables forced 0, ext_op=7; it still flows through with illegal=1.
- Latency: accepted instruction appears on outputs the next cycle.
- in_ready = FSM==IDLE && (!out_valid || out_ready).
- Transfer in on in_valid&&in_ready; out on out_valid&&out_ready.
- A simultaneous in/out transfer reloads the register with no bubble.
- Output register holds stable while out_valid && !out_ready.
- FSM:
  - IDLE: on accepting an M instruction → MWAIT, counter = (func3[2] ? DIV_LAT : MUL_LAT) − 1. mdu_start pulses in the next cycle, once.
  - MWAIT:
    - out_valid stays 1 and out_ready is ignored (no consumption) until the counter reaches 0; counter decrements each cycle.
    - At 0 → HOLD.
  - HOLD: bundle consumable; on out_ready → IDLE. Accept-in is blocked in the HOLD cycle.
- busy=1 in MWAIT/HOLD.
- in_valid dropped while in_ready=0 is legal; nothing is captured.
- Reset asserted mid-MWAIT aborts: no mdu_start and no output afterward.
- Counter width is $clog2(max(MUL_LAT,DIV_LAT))+1; LAT=1 goes directly from IDLE to HOLD.

Test Plan:
- Reset then addi x1,x0,5 (0x00500093), out_ready=1 → next cycle out_valid=1, ext_op=0, reg_wen=1, alu_op=0000, alu_bsrc=0, illegal=0; in_ready stays 1.
- Back-to-back sub (0x402081B3) then lui (0x123450B7), out_ready held 0 two cycles then 1 → sub bundle (alu_op=1000, alu_bsrc=1) stable, in_ready=0 while stalled; lui (alu_op=1111, ext_op=1) follows with no bubble.
- mul x3,x1,x2 (0x022081B3), ENABLE_M=1, MUL_LAT=3 → mdu_start single pulse, busy=1 for 3 cycles plus HOLD, reg_wb_sel=3, mdu_op=000; consumed only after count; next instruction accepted the cycle after.
- div (0x0220C1B3) with DIV_LAT=33 and rst pulsed at MWAIT cycle 10 → all outputs 0 immediately, busy=0, in_ready=1 after reset.
- 0x00000000, 0x0020B183 (ld), and mul with ENABLE_M=0 → illegal=1, reg_wen=mem_wen=do_jump=0, ext_op=7.
- beq (0x00208463) → do_branch=1, branch_cond=000, alu_asrc=1, ext_op=3, reg_wen=0.
